uart_rx: RTL and testbench

UART receiver for the same serial link as the team's UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no flow control. It runs entirely in the `clk` domain, oversampling the asynchronous `rx` line with a cycle counter instead of a derived clock. Each received byte is presented on `dout_rx` with a one-cycle `done_rx` strobe for the downstream consumer (FIFO or command parser).

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial input plus the received byte and its status strobes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout_rx;
  logic       done_rx;
  logic       frame_err;
  logic       parity_err;

  modport master (
    output rx,
    input  dout_rx,
    input  done_rx,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  rx,
    output dout_rx,
    output done_rx,
    output frame_err,
    output parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by a cycle counter in the clk domain.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data bit 7 and the stop bit.
module uart_rx #(
  parameter int clk_freq = 1_000_000,
  parameter int baud     = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int BIT  = clk_freq / baud;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT) + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    dout, dout_n;
  logic          done, done_n;
  logic          ferr, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_n;
  logic          perr, perr_n;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      dout    <= '0;
      done    <= 1'b0;
      ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      dout    <= dout_n;
      done    <= done_n;
      ferr    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_n;
      perr    <= perr_n;
`endif
    end
  end

  // Every sampling state clears cnt when it samples, so each bit period restarts at 0.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    dout_n    = dout;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n  = '0;
          dout_n = shreg;
`ifdef UART_RX_PARITY_EN
          perr_n = ^{shreg, par_bit};
`endif
          if (rx_s) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.dout_rx   = dout;
  assign bus.done_rx   = done;
  assign bus.frame_err = ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames checked against an event-level model of the receiver.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 9600;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int NBITS = PARITY_ON ? 10 : 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.clk_freq(CLK_FREQ), .baud(BAUD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       done;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && (bus.done_rx || bus.frame_err || bus.parity_err)) begin
      mon_e.done = bus.done_rx;
      mon_e.ferr = bus.frame_err;
      mon_e.perr = bus.parity_err;
      mon_e.data = bus.dout_rx;
      mon_e.cyc  = cyc;
      obs_q.push_back(mon_e);
    end
  end

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Model: a frame yields one event at a fixed offset from its start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    ev_t e;
    int  t0;
    t0 = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    if (PARITY_ON) drive_bit((^b) ^ par_flip, BIT);
    drive_bit(stop, BIT);
    e.done = stop;
    e.ferr = !stop;
    e.perr = PARITY_ON ? par_flip : 1'b0;
    e.data = b;
    e.cyc  = t0 + 2 + HALF + NBITS * BIT;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    int n;
    int d;
    check1({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check1({tag, ".flags"}, {obs_q[i].done, obs_q[i].ferr, obs_q[i].perr},
             {exp_q[i].done, exp_q[i].ferr, exp_q[i].perr});
      check1({tag, ".data"}, obs_q[i].data, exp_q[i].data);
      d = obs_q[i].cyc - exp_q[i].cyc;
      check1({tag, ".latency_ok"}, (d >= -1 && d <= 1), 1);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, ".dout"}, bus.dout_rx, 8'h00);
    check1({tag, ".done"}, bus.done_rx, 1'b0);
    check1({tag, ".ferr"}, bus.frame_err, 1'b0);
    check1({tag, ".perr"}, bus.parity_err, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    logic       rflip;
    int         gap;

    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("single");
    check1("single.hold", bus.dout_rx, 8'hA5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("b2b");

    drive_bit(1'b0, 30);
    idle(3 * BIT);
    check_events("glitch");
    check1("glitch.hold", bus.dout_rx, 8'hFF);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("after_glitch");

    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 2000);
    check_events("frame_err");
    check1("break.hold", bus.dout_rx, 8'h55);
    idle(2 * BIT);
    check_events("break_release");
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("after_break");

    // 0x81 aborted by reset halfway through data bit 4; line returns high with the reset.
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b0, HALF);
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    idle(12 * BIT);
    check_events("rst_mid_quiet");
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(2 * BIT);
    check_events("parity_ok");
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(2 * BIT);
    check_events("parity_bad");
`endif

    for (int k = 0; k < 12; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rflip = PARITY_ON ? 1'($urandom_range(0, 1)) : 1'b0;
      send_frame(rb, rstop, rflip);
      gap = $urandom_range(0, 40) + (rstop ? 0 : BIT);
      idle(gap);
    end
    idle(2 * BIT);
    check_events("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
